// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: shares one memory port between the core
// load/store path and a debug/loader port. The core has fixed priority;
// a starvation counter lets a long-refused debug request win a cycle.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // core load/store path
  input  logic                  CoreReq,
  input  logic                  CoreWE,
  input  logic [DATA_WIDTH-1:0] CoreAddr,
  input  logic [DATA_WIDTH-1:0] CoreWD,
  input  logic [2:0]            CoreFunct3,
  output logic                  CoreStall,
  output logic                  CoreValid,
  output logic [DATA_WIDTH-1:0] CoreRD,
  // debug/loader port
  input  logic                  DbgReq,
  input  logic                  DbgWE,
  input  logic [DATA_WIDTH-1:0] DbgAddr,
  input  logic [DATA_WIDTH-1:0] DbgWD,
  output logic                  DbgGnt,
  output logic                  DbgValid,
  output logic [DATA_WIDTH-1:0] DbgRD,
  // data memory port
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] MemA,
  output logic [DATA_WIDTH-1:0] MemWD,
  output logic [2:0]            MemFunct3,
  input  logic [DATA_WIDTH-1:0] MemRD
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [2:0]           F3_WORD   = 3'b010;

  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 dbg_prio;
  logic                 core_grant;
  logic                 dbg_grant;

  // Grant decision: core wins unless debug has been starved long enough
  always_comb begin
    dbg_prio   = (starve_cnt >= CNT_LIMIT);
    core_grant = CoreReq & ~dbg_prio;
    dbg_grant  = DbgReq & (~CoreReq | dbg_prio);
    CoreStall  = CoreReq & ~core_grant;
    DbgGnt     = dbg_grant;
  end

  // Memory port mux; write enable is suppressed while in reset
  always_comb begin
    MemWrite  = 1'b0;
    MemA      = '0;
    MemWD     = '0;
    MemFunct3 = 3'b000;
    if (core_grant) begin
      MemWrite  = CoreWE & rst_n;
      MemA      = CoreAddr;
      MemWD     = CoreWD;
      MemFunct3 = CoreFunct3;
    end else if (dbg_grant) begin
      MemWrite  = DbgWE & rst_n;
      MemA      = DbgAddr;
      MemWD     = DbgWD;
      MemFunct3 = F3_WORD;
    end
  end

  // Starvation counter: counts refused debug cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (dbg_grant || !DbgReq) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_WIDTH'(1);
    end
  end

  // Core read return: capture load data, valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      CoreValid <= 1'b0;
      CoreRD    <= '0;
    end else begin
      CoreValid <= core_grant & ~CoreWE;
      if (core_grant && !CoreWE) begin
        CoreRD <= MemRD;
      end
    end
  end

  // Debug read return: capture load data, valid for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DbgValid <= 1'b0;
      DbgRD    <= '0;
    end else begin
      DbgValid <= dbg_grant & ~DbgWE;
      if (dbg_grant && !DbgWE) begin
        DbgRD <= MemRD;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;
  localparam int unsigned CW  = 8;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          CoreReq, CoreWE, CoreStall, CoreValid;
  logic [DW-1:0] CoreAddr, CoreWD, CoreRD;
  logic [2:0]    CoreFunct3;
  logic          DbgReq, DbgWE, DbgGnt, DbgValid;
  logic [DW-1:0] DbgAddr, DbgWD, DbgRD;
  logic          MemWrite;
  logic [DW-1:0] MemA, MemWD, MemRD;
  logic [2:0]    MemFunct3;

  dmem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(LIM), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .CoreReq(CoreReq), .CoreWE(CoreWE), .CoreAddr(CoreAddr), .CoreWD(CoreWD),
    .CoreFunct3(CoreFunct3), .CoreStall(CoreStall), .CoreValid(CoreValid),
    .CoreRD(CoreRD),
    .DbgReq(DbgReq), .DbgWE(DbgWE), .DbgAddr(DbgAddr), .DbgWD(DbgWD),
    .DbgGnt(DbgGnt), .DbgValid(DbgValid), .DbgRD(DbgRD),
    .MemWrite(MemWrite), .MemA(MemA), .MemWD(MemWD), .MemFunct3(MemFunct3),
    .MemRD(MemRD)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int            m_wait;       // cycles the current debug request has been refused
  logic          exp_cv, exp_dv;
  logic [DW-1:0] exp_crd, exp_drd;
  logic          last_dg, last_stall;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wait  = 0;
    exp_cv  = 1'b0;
    exp_dv  = 1'b0;
    exp_crd = '0;
    exp_drd = '0;
  endtask

  // One clock cycle: inputs are set by the caller just after a rising edge.
  task automatic cycle();
    logic          prio, cg, dg, mw;
    logic [DW-1:0] ea, ewd;
    logic [2:0]    ef;
    prio = (m_wait >= int'(LIM));
    cg   = CoreReq && !prio;
    dg   = DbgReq && (!CoreReq || prio);
    if (cg) begin
      ea = CoreAddr; ewd = CoreWD; ef = CoreFunct3; mw = CoreWE;
    end else if (dg) begin
      ea = DbgAddr;  ewd = DbgWD;  ef = 3'b010;     mw = DbgWE;
    end else begin
      ea = '0; ewd = '0; ef = 3'b000; mw = 1'b0;
    end
    if (!rst_n) mw = 1'b0;
    #2;
    check("core_stall", DW'(CoreStall), DW'(CoreReq && !cg));
    check("dbg_gnt",    DW'(DbgGnt),    DW'(dg));
    check("mem_write",  DW'(MemWrite),  DW'(mw));
    check("mem_a",      MemA,           ea);
    check("mem_wd",     MemWD,          ewd);
    check("mem_funct3", DW'(MemFunct3), DW'(ef));
    last_dg    = dg;
    last_stall = CoreReq && !cg;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (DbgReq && !dg) m_wait = (m_wait < SAT) ? m_wait + 1 : SAT;
      else               m_wait = 0;
      exp_cv = cg && !CoreWE;
      if (exp_cv) exp_crd = MemRD;
      exp_dv = dg && !DbgWE;
      if (exp_dv) exp_drd = MemRD;
    end
    #1;
    check("core_valid", DW'(CoreValid), DW'(exp_cv));
    check("core_rd",    CoreRD,         exp_crd);
    check("dbg_valid",  DW'(DbgValid),  DW'(exp_dv));
    check("dbg_rd",     DbgRD,          exp_drd);
  endtask

  initial begin
    rst_n = 1'b1;
    CoreReq = 1'b0; CoreWE = 1'b0; CoreAddr = '0; CoreWD = '0; CoreFunct3 = 3'b000;
    DbgReq = 1'b0; DbgWE = 1'b0; DbgAddr = '0; DbgWD = '0; MemRD = '0;
    model_clear();
    last_dg = 1'b0; last_stall = 1'b0;

    // reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_core_valid", DW'(CoreValid), '0);
    check("rst_core_rd",    CoreRD,         '0);
    check("rst_dbg_valid",  DW'(DbgValid),  '0);
    check("rst_dbg_rd",     DbgRD,          '0);
    check("rst_mem_write",  DW'(MemWrite),  '0);
    check("rst_mem_a",      MemA,           '0);
    check("rst_stall",      DW'(CoreStall), '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // core load, uncontended
    CoreReq = 1'b1; CoreWE = 1'b0; CoreAddr = 32'h100; CoreFunct3 = 3'b010;
    MemRD = 32'hDEADBEEF;
    #1;
    check("ld_stall", DW'(CoreStall), '0);
    check("ld_mw",    DW'(MemWrite),  '0);
    cycle();
    check("ld_valid", DW'(CoreValid), 32'd1);
    check("ld_rd",    CoreRD,         32'hDEADBEEF);
    CoreReq = 1'b0; MemRD = 32'h0;
    cycle();
    check("ld_valid_drop", DW'(CoreValid), '0);
    check("ld_rd_hold",    CoreRD,         32'hDEADBEEF);

    // core byte store
    CoreReq = 1'b1; CoreWE = 1'b1; CoreAddr = 32'h40; CoreWD = 32'h12345678;
    CoreFunct3 = 3'b000; MemRD = 32'h11111111;
    #1;
    check("st_mw", DW'(MemWrite),  32'd1);
    check("st_a",  MemA,           32'h40);
    check("st_f3", DW'(MemFunct3), '0);
    cycle();
    check("st_no_valid", DW'(CoreValid), '0);
    CoreReq = 1'b0; CoreWE = 1'b0;

    // debug-only load
    DbgReq = 1'b1; DbgWE = 1'b0; DbgAddr = 32'h200; MemRD = 32'hCAFEF00D;
    #1;
    check("dld_gnt", DW'(DbgGnt),    32'd1);
    check("dld_f3",  DW'(MemFunct3), 32'd2);
    cycle();
    check("dld_valid", DW'(DbgValid), 32'd1);
    check("dld_rd",    DbgRD,         32'hCAFEF00D);
    DbgReq = 1'b0;

    // continuous core traffic against a pending debug load
    CoreReq = 1'b1; CoreWE = 1'b0; CoreAddr = 32'h1000; CoreFunct3 = 3'b010;
    DbgReq = 1'b1; DbgWE = 1'b0; DbgAddr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      MemRD = $urandom;
      #1;
      if (i < 4) begin
        check("starve_core_gnt", DW'(DbgGnt), '0);
      end else if (i == 4) begin
        check("starve_dbg_gnt", DW'(DbgGnt),    32'd1);
        check("starve_stall",   DW'(CoreStall), 32'd1);
        check("starve_mem_a",   MemA,           32'h300);
      end else begin
        check("starve_core_back", DW'(CoreStall), '0);
        check("starve_mem_a2",    MemA,           32'h1000);
      end
      cycle();
      if (i == 4) DbgReq = 1'b0;
    end
    CoreReq = 1'b0;

    // debug store contending with a core load
    CoreReq = 1'b1; CoreWE = 1'b0; CoreAddr = 32'h80;
    DbgReq = 1'b1; DbgWE = 1'b1; DbgAddr = 32'h84; DbgWD = 32'hA5A5A5A5;
    MemRD = 32'h0BADF00D;
    #1;
    check("dst_wait_gnt", DW'(DbgGnt),   '0);
    check("dst_wait_mw",  DW'(MemWrite), '0);
    cycle();
    CoreReq = 1'b0;
    #1;
    check("dst_gnt", DW'(DbgGnt),   32'd1);
    check("dst_mw",  DW'(MemWrite), 32'd1);
    check("dst_wd",  MemWD,         32'hA5A5A5A5);
    cycle();
    check("dst_no_valid", DW'(DbgValid), '0);
    DbgReq = 1'b0; DbgWE = 1'b0;

    // reset right after a granted core load
    CoreReq = 1'b1; CoreWE = 1'b0; CoreAddr = 32'h10; MemRD = 32'h5555AAAA;
    cycle();
    check("pre_rst_valid", DW'(CoreValid), 32'd1);
    CoreWE = 1'b1; CoreWD = 32'hFFFFFFFF;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", DW'(CoreValid), '0);
    check("mid_rst_rd",    CoreRD,         '0);
    check("mid_rst_mw",    DW'(MemWrite),  '0);
    model_clear();
    cycle();
    rst_n = 1'b1;
    CoreReq = 1'b0; CoreWE = 1'b0;
    last_stall = 1'b0; last_dg = 1'b0;

    // randomized traffic; stalled core and refused debug hold their request
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        CoreReq    = (i >= 200 && i < 320) ? 1'b1 : ($urandom_range(0, 9) < 7);
        CoreWE     = ($urandom_range(0, 2) == 0);
        CoreAddr   = $urandom;
        CoreWD     = $urandom;
        CoreFunct3 = 3'($urandom_range(0, 7));
      end
      if (!(DbgReq && !last_dg)) begin
        DbgReq  = ($urandom_range(0, 2) == 0);
        DbgWE   = ($urandom_range(0, 1) == 0);
        DbgAddr = $urandom;
        DbgWD   = $urandom;
      end
      MemRD = $urandom;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
